// File: rtl/tiro_uc_if.sv
// Control/status bundle between the shot-sweep controller and its datapath.
// The master side drives the datapath flags and commands; the slave side is the controller.
interface tiro_uc_if;
    logic       iniciar;
    logic       disparar;
    logic       rco_contador;
    logic       loaded;
    logic [1:0] opcode;
    logic       x_borda_min;
    logic       x_borda_max;
    logic       y_borda_min;
    logic       y_borda_max;

    logic       conta_contador;
    logic       reset_cont;
    logic [1:0] select_mux_pos;
    logic       select_mux_coor;
    logic       select_soma_sub;
    logic       enable_mem_aste;
    logic       enable_mem_load;
    logic       new_load;
    logic       ocupado;
    logic       pronto;
    logic       recusado;
    logic [3:0] db_estado;

    modport master (
        output iniciar, disparar, rco_contador, loaded, opcode,
               x_borda_min, x_borda_max, y_borda_min, y_borda_max,
        input  conta_contador, reset_cont, select_mux_pos, select_mux_coor,
               select_soma_sub, enable_mem_aste, enable_mem_load, new_load,
               ocupado, pronto, recusado, db_estado
    );

    modport slave (
        input  iniciar, disparar, rco_contador, loaded, opcode,
               x_borda_min, x_borda_max, y_borda_min, y_borda_max,
        output conta_contador, reset_cont, select_mux_pos, select_mux_coor,
               select_soma_sub, enable_mem_aste, enable_mem_load, new_load,
               ocupado, pronto, recusado, db_estado
    );
endinterface

// File: rtl/tiro_uc.sv
// Shot-sweep controller: walks 16 shot slots, moving, discarding or creating shots.
// Moore FSM; state-only outputs are registered from the next state.
module tiro_uc (
    input  logic     clock,
    input  logic     reset,
    tiro_uc_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ZERA     = 4'd1,
        LE       = 4'd2,
        AVALIA   = 4'd3,
        MOVE     = 4'd4,
        DESCARTA = 4'd5,
        CRIA     = 4'd6,
        PROX     = 4'd7,
        FIM      = 4'd8
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   r_pendente;
    logic   r_criado;
    logic   r_reset_cont;
    logic   r_enable_mem_aste;
    logic   r_enable_mem_load;
    logic   r_new_load;
    logic   r_ocupado;
    logic   r_pronto;
    logic   w_borda;
    logic   w_calc;

    always_comb begin
        w_borda = bus.x_borda_max;
        case (bus.opcode)
            2'b00:   w_borda = bus.y_borda_min;
            2'b01:   w_borda = bus.y_borda_max;
            2'b10:   w_borda = bus.x_borda_min;
            default: w_borda = bus.x_borda_max;
        endcase
    end

    // r_criado guarantees a single creation per sweep even if a new request lands on CRIA
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (bus.iniciar) w_state_next = ZERA;
            ZERA:     w_state_next = LE;
            LE:       w_state_next = AVALIA;
            AVALIA: begin
                if (!bus.loaded)
                    w_state_next = (r_pendente && !r_criado) ? CRIA : PROX;
                else if (w_borda)
                    w_state_next = DESCARTA;
                else
                    w_state_next = MOVE;
            end
            MOVE, DESCARTA, CRIA: w_state_next = PROX;
            PROX:     w_state_next = bus.rco_contador ? FIM : LE;
            FIM:      w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state           <= IDLE;
            r_pendente        <= 1'b0;
            r_criado          <= 1'b0;
            r_reset_cont      <= 1'b0;
            r_enable_mem_aste <= 1'b0;
            r_enable_mem_load <= 1'b0;
            r_new_load        <= 1'b0;
            r_ocupado         <= 1'b0;
            r_pronto          <= 1'b0;
        end else begin
            r_state           <= w_state_next;
            r_reset_cont      <= (w_state_next == ZERA);
            r_enable_mem_aste <= (w_state_next == MOVE) || (w_state_next == CRIA);
            r_enable_mem_load <= (w_state_next == DESCARTA) || (w_state_next == CRIA);
            r_new_load        <= (w_state_next == CRIA);
            r_ocupado         <= (w_state_next != IDLE);
            r_pronto          <= (w_state_next == FIM);

            if (bus.disparar)
                r_pendente <= 1'b1;
            else if ((r_state == CRIA) || (r_state == FIM))
                r_pendente <= 1'b0;

            if (r_state == ZERA)
                r_criado <= 1'b0;
            else if (r_state == CRIA)
                r_criado <= 1'b1;
        end
    end

    // Adder controls follow the slot's opcode, which is only valid once the read has settled
    assign w_calc              = (r_state == AVALIA) || (r_state == MOVE);
    assign bus.select_mux_coor = w_calc & ~bus.opcode[1];
    assign bus.select_soma_sub = w_calc & ~bus.opcode[0];
    assign bus.select_mux_pos  = (r_state == CRIA) ? 2'b11 :
                                 (r_state == MOVE) ? (bus.opcode[1] ? 2'b01 : 2'b10) : 2'b00;
    assign bus.conta_contador  = (r_state == PROX) & ~bus.rco_contador;
    assign bus.recusado        = (r_state == FIM) & r_pendente;
    assign bus.db_estado       = r_state;

    assign bus.reset_cont      = r_reset_cont;
    assign bus.enable_mem_aste = r_enable_mem_aste;
    assign bus.enable_mem_load = r_enable_mem_load;
    assign bus.new_load        = r_new_load;
    assign bus.ocupado         = r_ocupado;
    assign bus.pronto          = r_pronto;
endmodule

// File: tb/tb_tiro_uc.sv
// Bench for tiro_uc: a behavioural slot memory/counter around the DUT, a per-sweep
// reference model feeding a scoreboard queue, and a monitor that checks each slot and sweep end.
module tb_tiro_uc;
    logic clock = 1'b0;
    logic reset = 1'b0;

    tiro_uc_if bus();

    tiro_uc dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    localparam logic [3:0] SHIP_X = 4'd7;
    localparam logic [3:0] SHIP_Y = 4'd14;

    // Slot memory and counter seen by the controller
    logic       m_ld [16];
    logic [1:0] m_op [16];
    logic [3:0] m_x  [16];
    logic [3:0] m_y  [16];
    logic [3:0] cnt;
    logic [3:0] w_sum;

    // Preset contents written by the stimulus, copied in on do_load
    logic       p_ld [16];
    logic [1:0] p_op [16];
    logic [3:0] p_x  [16];
    logic [3:0] p_y  [16];
    logic       do_load = 1'b0;

    assign w_sum = (bus.select_mux_coor ? m_y[cnt] : m_x[cnt]) +
                   (bus.select_soma_sub ? 4'hF : 4'h1);
    assign bus.loaded       = m_ld[cnt];
    assign bus.opcode       = m_op[cnt];
    assign bus.x_borda_min  = (m_x[cnt] == 4'd0);
    assign bus.x_borda_max  = (m_x[cnt] == 4'd14);
    assign bus.y_borda_min  = (m_y[cnt] == 4'd0);
    assign bus.y_borda_max  = (m_y[cnt] == 4'd14);
    assign bus.rco_contador = (cnt == 4'd15);

    always @(posedge clock) begin
        if (do_load) begin
            for (int i = 0; i < 16; i++) begin
                m_ld[i] <= p_ld[i];
                m_op[i] <= p_op[i];
                m_x[i]  <= p_x[i];
                m_y[i]  <= p_y[i];
            end
            cnt <= 4'd0;
        end else begin
            if (bus.reset_cont)
                cnt <= 4'd0;
            else if (bus.conta_contador)
                cnt <= cnt + 4'd1;
            if (bus.enable_mem_aste) begin
                case (bus.select_mux_pos)
                    2'b01: m_x[cnt] <= w_sum;
                    2'b10: m_y[cnt] <= w_sum;
                    2'b11: begin
                        m_x[cnt] <= SHIP_X;
                        m_y[cnt] <= SHIP_Y;
                    end
                    default: ;
                endcase
            end
            if (bus.enable_mem_load)
                m_ld[cnt] <= bus.new_load;
        end
    end

    logic [15:0] all_out;
    assign all_out = {bus.reset_cont, bus.conta_contador, bus.select_mux_pos,
                      bus.select_mux_coor, bus.select_soma_sub, bus.enable_mem_aste,
                      bus.enable_mem_load, bus.new_load, bus.ocupado, bus.pronto,
                      bus.recusado, bus.db_estado};

    typedef struct {
        bit         is_end;
        int         slot;
        logic [3:0] st;
        logic [6:0] ctl;
        int         len;
        bit         rec;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   cyc = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: records the action cycle of each slot, pops and compares at PROX / FIM
    initial begin : monitor
        exp_t       e;
        logic [3:0] st;
        logic [6:0] ctl;
        logic [3:0] act_st = 4'd0;
        logic [6:0] act_ctl = 7'd0;
        int         zera_cyc = 0;
        forever begin
            @(negedge clock);
            cyc++;
            if (mon_en) begin
                st  = bus.db_estado;
                ctl = {bus.enable_mem_aste, bus.enable_mem_load, bus.new_load,
                       bus.select_mux_pos, bus.select_mux_coor, bus.select_soma_sub};
                check("ocupado", int'(bus.ocupado), int'(st != 4'd0));
                if (st != 4'd8)
                    check("recusado_outside_fim", int'(bus.recusado), 0);
                case (st)
                    4'd1: begin
                        zera_cyc = cyc;
                        act_st   = 4'd0;
                        act_ctl  = 7'd0;
                        check("zera_reset_cont", int'(bus.reset_cont), 1);
                    end
                    4'd2: check("le_no_controls",
                                int'({ctl, bus.conta_contador, bus.reset_cont, bus.pronto}), 0);
                    4'd4, 4'd5, 4'd6: begin
                        act_st  = st;
                        act_ctl = ctl;
                    end
                    4'd7: begin
                        if (exp_q.size() == 0 || exp_q[0].is_end) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_slot: got slot end at cycle %0d, expected none", cyc);
                        end else begin
                            e = exp_q.pop_front();
                            check($sformatf("slot%0d_action_state", e.slot), int'(act_st), int'(e.st));
                            check($sformatf("slot%0d_controls", e.slot), int'(act_ctl), int'(e.ctl));
                            check($sformatf("slot%0d_conta", e.slot), int'(bus.conta_contador),
                                  int'(e.slot != 15));
                        end
                        act_st  = 4'd0;
                        act_ctl = 7'd0;
                    end
                    4'd8: begin
                        if (exp_q.size() == 0 || !exp_q[0].is_end) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_fim: got FIM at cycle %0d, expected more slots", cyc);
                        end else begin
                            e = exp_q.pop_front();
                            check("fim_pronto", int'(bus.pronto), 1);
                            check("fim_recusado", int'(bus.recusado), int'(e.rec));
                            check("sweep_length", cyc - zera_cyc + 1, e.len);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_mem();
        do_load = 1'b1;
        tick();
        do_load = 1'b0;
    endtask

    task automatic fire_pulse();
        bus.disparar = 1'b1;
        tick();
        bus.disparar = 1'b0;
    endtask

    function automatic bit at_border(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y);
        case (op)
            2'd0:    return y == 4'd0;
            2'd1:    return y == 4'd14;
            2'd2:    return x == 4'd0;
            default: return x == 4'd14;
        endcase
    endfunction

    task automatic clear_slots();
        for (int k = 0; k < 16; k++) begin
            p_ld[k] = 1'b0;
            p_op[k] = 2'd0;
            p_x[k]  = 4'd5;
            p_y[k]  = 4'd5;
        end
    endtask

    task automatic random_slots(input bit all_loaded);
        for (int k = 0; k < 16; k++) begin
            p_ld[k] = all_loaded ? 1'b1 : 1'($urandom_range(0, 1));
            p_op[k] = 2'($urandom_range(0, 3));
            p_x[k]  = 4'($urandom_range(1, 13));
            p_y[k]  = 4'($urandom_range(1, 13));
            if (!all_loaded && $urandom_range(0, 3) == 0) begin
                case (p_op[k])
                    2'd0:    p_y[k] = 4'd0;
                    2'd1:    p_y[k] = 4'd14;
                    2'd2:    p_x[k] = 4'd0;
                    default: p_x[k] = 4'd14;
                endcase
            end
        end
    endtask

    // Reference: each slot either idles, moves one step, is discarded, or receives the new shot
    task automatic run_sweep(input bit pre_fire, input bit mid_fire, input int fire_at);
        exp_t       e;
        bit         pend = pre_fire;
        int         len = 2;
        int         n;
        logic       e_ld [16];
        logic [3:0] e_x  [16];
        logic [3:0] e_y  [16];
        for (int k = 0; k < 16; k++) begin
            e_ld[k]  = p_ld[k];
            e_x[k]   = p_x[k];
            e_y[k]   = p_y[k];
            e.is_end = 1'b0;
            e.slot   = k;
            e.len    = 0;
            e.rec    = 1'b0;
            if (!p_ld[k]) begin
                if (pend) begin
                    e.st  = 4'd6;
                    e.ctl = 7'b111_11_0_0;
                    pend  = 1'b0;
                    e_ld[k] = 1'b1;
                    e_x[k]  = SHIP_X;
                    e_y[k]  = SHIP_Y;
                end else begin
                    e.st  = 4'd0;
                    e.ctl = 7'd0;
                end
            end else if (at_border(p_op[k], p_x[k], p_y[k])) begin
                e.st    = 4'd5;
                e.ctl   = 7'b010_00_0_0;
                e_ld[k] = 1'b0;
            end else begin
                e.st = 4'd4;
                case (p_op[k])
                    2'd0: begin e.ctl = 7'b100_10_1_1; e_y[k] = p_y[k] - 4'd1; end
                    2'd1: begin e.ctl = 7'b100_10_1_0; e_y[k] = p_y[k] + 4'd1; end
                    2'd2: begin e.ctl = 7'b100_01_0_1; e_x[k] = p_x[k] - 4'd1; end
                    default: begin e.ctl = 7'b100_01_0_0; e_x[k] = p_x[k] + 4'd1; end
                endcase
            end
            len += (e.st == 4'd0) ? 3 : 4;
            exp_q.push_back(e);
        end
        e.is_end = 1'b1;
        e.slot   = 16;
        e.st     = 4'd8;
        e.ctl    = 7'd0;
        e.len    = len;
        e.rec    = pend || mid_fire;
        exp_q.push_back(e);

        load_mem();
        if (pre_fire)
            fire_pulse();
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
        check("zera_after_iniciar", int'(bus.db_estado), 1);
        if (mid_fire) begin
            for (int c = 0; c < fire_at; c++)
                tick();
            fire_pulse();
        end
        n = 0;
        while (bus.ocupado && n < 300) begin
            tick();
            n++;
        end
        check("sweep_completes_in_budget", int'(n < 300), 1);
        check("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
        for (int k = 0; k < 16; k++)
            check($sformatf("mem_slot%0d_ld_x_y", k), int'({m_ld[k], m_x[k], m_y[k]}),
                  int'({e_ld[k], e_x[k], e_y[k]}));
        $display("sweep pre_fire=%0d mid_fire=%0d length=%0d recusado=%0d", pre_fire, mid_fire, len, e.rec);
    endtask

    initial begin : stimulus
        int n;
        bus.iniciar  = 1'b0;
        bus.disparar = 1'b0;
        clear_slots();
        load_mem();
        bus.iniciar = 1'b1;
        repeat (3) tick();
        bus.iniciar = 1'b0;
        check("reset_state", int'(bus.db_estado), 0);
        check("reset_outputs", int'(all_out), 0);
        reset = 1'b1;
        tick();
        check("idle_after_reset", int'(bus.db_estado), 0);
        mon_en = 1'b1;

        clear_slots();
        run_sweep(1'b0, 1'b0, 0);

        clear_slots();
        p_ld[3] = 1'b1; p_op[3] = 2'd3; p_x[3] = 4'd5;
        run_sweep(1'b0, 1'b0, 0);

        clear_slots();
        p_ld[5] = 1'b1; p_op[5] = 2'd0; p_y[5] = 4'd0;
        run_sweep(1'b0, 1'b0, 0);

        clear_slots();
        p_ld[0] = 1'b1; p_ld[1] = 1'b1;
        run_sweep(1'b1, 1'b0, 0);

        random_slots(1'b1);
        run_sweep(1'b0, 1'b1, 20);

        random_slots(1'b1);
        run_sweep(1'b1, 1'b0, 0);

        for (int r = 0; r < 12; r++) begin
            random_slots(1'b0);
            run_sweep(1'($urandom_range(0, 1)), 1'b0, 0);
        end

        // Reset taken in the middle of a MOVE at slot 7
        mon_en = 1'b0;
        clear_slots();
        p_ld[7] = 1'b1; p_op[7] = 2'd3; p_x[7] = 4'd5;
        load_mem();
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
        n = 0;
        while (!(bus.db_estado == 4'd4 && cnt == 4'd7) && n < 300) begin
            tick();
            n++;
        end
        check("reach_move_slot7", int'(n < 300), 1);
        reset = 1'b0;
        tick();
        check("midsweep_reset_state", int'(bus.db_estado), 0);
        check("midsweep_reset_outputs", int'(all_out), 0);
        reset = 1'b1;
        tick();
        check("idle_after_midsweep_reset", int'(bus.db_estado), 0);
        exp_q.delete();
        mon_en = 1'b1;
        random_slots(1'b0);
        run_sweep(1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
